// File: rtl/hex_text_pkg.sv
// Character codes, FSM states and segment constants shared by the scrolling text display.
package hex_text_pkg;

  typedef logic [4:0] char_t;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_SCROLL,
    ST_DWELL
  } state_e;

  localparam char_t CH_0     = 5'h00;
  localparam char_t CH_F     = 5'h0F;
  localparam char_t CH_C     = 5'h10;
  localparam char_t CH_R     = 5'h11;
  localparam char_t CH_O     = 5'h12;
  localparam char_t CH_L     = 5'h13;
  localparam char_t CH_H     = 5'h14;
  localparam char_t CH_P     = 5'h15;
  localparam char_t CH_U     = 5'h16;
  localparam char_t CH_N     = 5'h17;
  localparam char_t CH_T     = 5'h18;
  localparam char_t CH_Y     = 5'h19;
  localparam char_t CH_DASH  = 5'h1A;
  localparam char_t CH_BLANK = 5'h1F;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_char_font.sv
// Combinational character font: 5-bit code to active-low {g,f,e,d,c,b,a} segments.
module hex_char_font
  import hex_text_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      5'h00:   seg = 7'b1000000;
      5'h01:   seg = 7'b1111001;
      5'h02:   seg = 7'b0100100;
      5'h03:   seg = 7'b0110000;
      5'h04:   seg = 7'b0011001;
      5'h05:   seg = 7'b0010010;
      5'h06:   seg = 7'b0000010;
      5'h07:   seg = 7'b1111000;
      5'h08:   seg = 7'b0000000;
      5'h09:   seg = 7'b0010000;
      5'h0A:   seg = 7'b0001000;
      5'h0B:   seg = 7'b0000011;
      5'h0C:   seg = 7'b1000110;
      5'h0D:   seg = 7'b0100001;
      5'h0E:   seg = 7'b0000110;
      5'h0F:   seg = 7'b0001110;
      CH_C:    seg = 7'b1000110;
      CH_R:    seg = 7'b0101111;
      CH_O:    seg = 7'b0100011;
      CH_L:    seg = 7'b1000111;
      CH_H:    seg = 7'b0001001;
      CH_P:    seg = 7'b0001100;
      CH_U:    seg = 7'b1000001;
      CH_N:    seg = 7'b0101011;
      CH_T:    seg = 7'b0000111;
      CH_Y:    seg = 7'b0010001;
      CH_DASH: seg = 7'b0111111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_text_scroller.sv
// Scrolls a writable message across NUM_DIGITS active-low 7-seg digits.
// Optional end-of-lap pause enabled by defining HEX_SCROLL_DWELL_EN.
module hex_text_scroller
  import hex_text_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int MSG_LEN     = 16,
  parameter int STEP_DIV    = 12500000,
  parameter int PAUSE_STEPS = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic                       RUN,
  input  logic                       DIR,
  input  logic                       WR_EN,
  input  logic [$clog2(MSG_LEN)-1:0] WR_ADDR,
  input  logic [4:0]                 WR_CHAR,
  output logic [7*NUM_DIGITS-1:0]    HEX,
  output logic [$clog2(MSG_LEN)-1:0] OFFSET,
  output logic                       WRAP
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int DW = $clog2(STEP_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
  localparam logic [AW:0]   LEN_W    = (AW + 1)'(MSG_LEN);

  if (MSG_LEN < NUM_DIGITS) begin : g_bad_len
    $error("hex_text_scroller: MSG_LEN must be >= NUM_DIGITS");
  end
  if (STEP_DIV < 2 || PAUSE_STEPS < 1) begin : g_bad_rate
    $error("hex_text_scroller: STEP_DIV must be >= 2 and PAUSE_STEPS >= 1");
  end

  state_e                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [AW-1:0]           off_q, off_d;
  logic                    wrap_q, wrap_d;
  char_t                   msg_q [MSG_LEN];
  char_t                   msg_d [MSG_LEN];
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [6:0]              seg [NUM_DIGITS];
  logic                    tick;

`ifdef HEX_SCROLL_DWELL_EN
  localparam int DCW = $clog2(PAUSE_STEPS + 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(PAUSE_STEPS - 1);
  logic [DCW-1:0] dwell_q, dwell_d;
`endif

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    off_d   = off_q;
    wrap_d  = 1'b0;
`ifdef HEX_SCROLL_DWELL_EN
    dwell_d = dwell_q;
`endif
    case (state_q)
      ST_STOPPED: begin
        div_d = '0;
        if (RUN) state_d = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (!RUN) begin
          state_d = ST_STOPPED;
          div_d   = '0;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            if (DIR) begin
              off_d  = (off_q == '0) ? OFF_LAST : off_q - 1'b1;
              wrap_d = (off_q == '0);
            end else begin
              off_d  = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
              wrap_d = (off_q == OFF_LAST);
            end
`ifdef HEX_SCROLL_DWELL_EN
            // Landing on the message start, from either direction, begins a pause.
            if (off_d == '0) begin
              state_d = ST_DWELL;
              dwell_d = '0;
            end
`endif
          end
        end
      end
`ifdef HEX_SCROLL_DWELL_EN
      ST_DWELL: begin
        if (!RUN) begin
          state_d = ST_STOPPED;
          div_d   = '0;
          dwell_d = '0;
        end else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick) begin
            if (dwell_q == DWELL_LAST) begin
              state_d = ST_SCROLL;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = ST_STOPPED;
    endcase
  end

  always_comb begin
    msg_d = msg_q;
    if (WR_EN && ({1'b0, WR_ADDR} < LEN_W)) msg_d[WR_ADDR] = WR_CHAR;
  end

  // offset + k never exceeds 2*MSG_LEN-2, so one conditional subtract wraps it.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [AW:0]   sum;
    logic [AW-1:0] idx;
    assign sum = {1'b0, off_q} + (AW + 1)'(k);
    assign idx = (sum >= LEN_W) ? AW'(sum - LEN_W) : sum[AW-1:0];
    hex_char_font u_font (
      .code(msg_q[idx]),
      .seg (seg[k])
    );
  end

  always_comb begin
    hex_d = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      hex_d[7*(NUM_DIGITS-1-k) +: 7] = seg[k];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_STOPPED;
      div_q   <= '0;
      off_q   <= '0;
      wrap_q  <= 1'b0;
      hex_q   <= '1;
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= CH_BLANK;
`ifdef HEX_SCROLL_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      off_q   <= off_d;
      wrap_q  <= wrap_d;
      hex_q   <= hex_d;
      msg_q   <= msg_d;
`ifdef HEX_SCROLL_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  assign HEX    = hex_q;
  assign OFFSET = off_q;
  assign WRAP   = wrap_q;

endmodule

// File: tb/tb_hex_text_scroller.sv
// Scoreboard bench for hex_text_scroller: a behavioural model pushes expected outputs per edge.
module tb_hex_text_scroller;

  localparam int ND = 6;
  localparam int ML = 8;
  localparam int SD = 4;
  localparam int PS = 2;

  logic        clk = 1'b0;
  logic        rst, run, dir, wr_en;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_char;
  logic [41:0] hex;
  logic [2:0]  offset;
  logic        wrap;

  logic        run6, wr_en6;
  logic [2:0]  wr_addr6;
  logic [4:0]  wr_char6;
  logic [41:0] hex6;
  logic [2:0]  offset6;
  logic        wrap6;

  always #5 clk = ~clk;

  hex_text_scroller #(.NUM_DIGITS(ND), .MSG_LEN(ML), .STEP_DIV(SD), .PAUSE_STEPS(PS)) u_dut (
    .CLOCK_50(clk), .RESET(rst), .RUN(run), .DIR(dir), .WR_EN(wr_en),
    .WR_ADDR(wr_addr), .WR_CHAR(wr_char), .HEX(hex), .OFFSET(offset), .WRAP(wrap)
  );

  hex_text_scroller #(.NUM_DIGITS(6), .MSG_LEN(6), .STEP_DIV(SD), .PAUSE_STEPS(PS)) u_dut6 (
    .CLOCK_50(clk), .RESET(rst), .RUN(run6), .DIR(1'b0), .WR_EN(wr_en6),
    .WR_ADDR(wr_addr6), .WR_CHAR(wr_char6), .HEX(hex6), .OFFSET(offset6), .WRAP(wrap6)
  );

  typedef struct {
    logic [2:0]  off;
    logic        wrap;
    logic [41:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int          m_msg [ML];
  int          m_off, m_div, m_st, m_dw;
  logic [41:0] m_hex;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [6:0] fnt(input int c);
    case (c)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      16: return 7'h46; 17: return 7'h2F;  18: return 7'h23;  19: return 7'h47;
      20: return 7'h09; 21: return 7'h0C;  22: return 7'h41;  23: return 7'h2B;
      24: return 7'h07; 25: return 7'h11;  26: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Model of one rising edge using the inputs currently applied; states 0/1/2 = stopped/scroll/dwell.
  task automatic model_edge(output exp_t e);
    logic [41:0] h;
    int nxt;
    bit tk;
    e.wrap = 1'b0;
    if (rst) begin
      for (int i = 0; i < ML; i++) m_msg[i] = 31;
      m_off = 0; m_div = 0; m_st = 0; m_dw = 0; m_hex = '1;
    end else begin
      for (int k = 0; k < ND; k++) h[7*(ND-1-k) +: 7] = fnt(m_msg[(m_off + k) % ML]);
      m_hex = h;
      if (wr_en && int'(wr_addr) < ML) m_msg[wr_addr] = int'(wr_char);
      if (m_st == 0) begin
        m_div = 0;
        if (run) m_st = 1;
      end else if (!run) begin
        m_st = 0; m_div = 0; m_dw = 0;
      end else begin
        tk = (m_div == SD - 1);
        m_div = tk ? 0 : m_div + 1;
        if (tk && m_st == 1) begin
          nxt = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
          e.wrap = dir ? (m_off == 0) : (m_off == ML - 1);
          m_off = nxt;
`ifdef HEX_SCROLL_DWELL_EN
          if (nxt == 0) begin m_st = 2; m_dw = 0; end
`endif
        end else if (tk && m_st == 2) begin
          if (m_dw == PS - 1) begin m_st = 1; m_dw = 0; end
          else m_dw++;
        end
      end
    end
    e.off = 3'(m_off);
    e.hex = m_hex;
  endtask

  task automatic step();
    exp_t e, g;
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("offset", 64'(offset), 64'(g.off));
    check("wrap",   64'(wrap),   64'(g.wrap));
    check("hex",    64'(hex),    64'(g.hex));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wraps, saved, addr;
    int msg [ML] = '{5, 16, 17, 18, 19, 19, 26, 26};
    rst = 1; run = 0; dir = 0; wr_en = 0; wr_addr = '0; wr_char = '0;
    run6 = 0; wr_en6 = 0; wr_addr6 = '0; wr_char6 = '0;
    step(); step();
    check("rst_hex", 64'(hex), {22'h0, 42'h3FF_FFFF_FFFF});
    rst = 0;
    repeat (20) step();
    check("idle_off", 64'(offset), 64'd0);

    for (int i = 0; i < ML; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_char = 5'(msg[i]);
      step();
    end
    wr_en = 0;
    step(); step();
    check("right_L", 64'(hex[6:0]), 64'(7'b1000111));
    check("left_5",  64'(hex[41:35]), 64'(7'b0010010));

    run = 1; dir = 0;
    n = 0;
    while (offset != 3'd3 && n < 40) begin step(); n++; end
    check("reach_off3", 64'(offset), 64'd3);
    step();
    check("left_o", 64'(hex[41:35]), 64'(7'b0100011));

    wraps = 0; n = 0;
    do begin step(); n++; if (wrap) wraps++; end while (offset != 3'd0 && n < 60);
    check("lap_wraps", 64'(wraps), 64'd1);

    n = 0;
    do begin step(); n++; end while (offset == 3'd0 && n < 80);
`ifdef HEX_SCROLL_DWELL_EN
    check("dwell_len", 64'(n), 64'(SD * (PS + 1)));
`else
    check("dwell_len", 64'(n), 64'(SD));
`endif
    check("after_0", 64'(offset), 64'd1);

    dir = 1;
    n = 0;
    while (offset != 3'd7 && n < 80) begin step(); n++; end
    check("rev_wrap_off", 64'(offset), 64'd7);
    check("rev_wrap_pulse", 64'(wrap), 64'd1);

    step(); step();
    run = 0;
    saved = int'(offset);
    repeat (10) step();
    check("frozen", 64'(offset), 64'(saved));
    run = 1;
    n = 0;
    do begin step(); n++; end while (int'(offset) == saved && n < 40);
    check("restart", 64'(n), 64'(SD + 1));

    dir = 0;
    n = 0;
    while (m_div != SD - 1 && n < 8) begin step(); n++; end
    addr = (m_off + 1) % ML;
    wr_en = 1; wr_addr = 3'(addr); wr_char = 5'h14;
    step();
    wr_en = 0;
    step();
    check("wt_off", 64'(offset), 64'(addr));
    check("wt_left_H", 64'(hex[41:35]), 64'(7'b0001001));

    rst = 1;
    step();
    rst = 0;
    check("mid_rst_off", 64'(offset), 64'd0);
    check("mid_rst_hex", 64'(hex), {22'h0, 42'h3FF_FFFF_FFFF});

    wr_en6 = 1; wr_char6 = 5'h08;
    wr_addr6 = 3'd6; step();
    wr_addr6 = 3'd7; step();
    wr_en6 = 0;
    step(); step();
    check("oor_ignored", 64'(hex6), {22'h0, 42'h3FF_FFFF_FFFF});
    wr_en6 = 1; wr_addr6 = 3'd5; step();
    wr_en6 = 0;
    step();
    check("inrange_wr", 64'(hex6[6:0]), 64'(7'b0000000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
